// File: rtl/mux_types_pkg.sv
// rtl/mux_types_pkg.sv - shared mux select, ALU opcode and forwarding types
package mux_types_pkg;

    // ALU operations; encodings 10..15 are unused and produce a zero result
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Source of ALU operand B
    typedef enum logic [1:0] {
        BSEL_RDAT2 = 2'd0,
        BSEL_EXT32 = 2'd1,
        BSEL_SHAMT = 2'd2,
        BSEL_LUI   = 2'd3
    } aluBMux;

    // Source of the register-file write data, carried through to writeback
    typedef enum logic [1:0] {
        RFIN_ALU  = 2'd0,
        RFIN_DMEM = 2'd1,
        RFIN_NPC  = 2'd2,
        RFIN_IMM  = 2'd3
    } rfInMux;

    // Which pipeline stage supplies a source operand
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwdSel_t;

    // The younger MEM result wins over WB; $0 is hard-wired and never forwarded
    function automatic fwdSel_t fwd_select(
        input logic [4:0] src,
        input logic [4:0] mem_dst,
        input logic       mem_wen,
        input logic [4:0] wb_dst,
        input logic       wb_wen
    );
        fwdSel_t sel;
        sel = FWD_NONE;
        if (src != 5'd0) begin
            if (mem_wen && (mem_dst == src)) begin
                sel = FWD_MEM;
            end else if (wb_wen && (wb_dst == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with zero and signed-overflow flags
module alu
    import mux_types_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  aluop_t      aluop,
    output logic [31:0] out,
    output logic        zero,
    output logic        overflow
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Operation select; shifts take their amount from A so SHAMT/register shifts share a path
    always_comb begin
        out      = 32'h0;
        overflow = 1'b0;
        case (aluop)
            ALU_SLL:  out = b << a[4:0];
            ALU_SRL:  out = b >> a[4:0];
            ALU_ADD: begin
                out      = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                out      = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_XOR:  out = a ^ b;
            ALU_NOR:  out = ~(a | b);
            ALU_SLT:  out = {31'h0, ($signed(a) < $signed(b))};
            ALU_SLTU: out = {31'h0, (a < b)};
            default:  out = 32'h0;
        endcase
    end

    assign zero = (out == 32'h0);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, B mux, ALU and EX/MEM register
module ex_stage
    import mux_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        EN,
    input  logic        flush,
    input  logic [31:0] instr_i,
    input  logic [31:0] pipe_npc_i,
    input  logic [31:0] rdat1_i,
    input  logic [31:0] rdat2_i,
    input  logic [31:0] ext32_i,
    input  logic [31:0] extshamt_i,
    input  aluBMux      aluBSel_i,
    input  aluop_t      aluop_i,
    input  logic [4:0]  wsel_i,
    input  rfInMux      rfInSel_i,
    input  logic        rfWEN_i,
    input  logic        dREN_i,
    input  logic        dWEN_i,
    input  logic        halt_i,
    input  logic [4:0]  mem_wsel,
    input  logic        mem_rfWEN,
    input  logic [31:0] mem_data,
    input  logic [4:0]  wb_wsel,
    input  logic        wb_rfWEN,
    input  logic [31:0] wb_data,
    output logic [31:0] aluout_o,
    output logic [31:0] storedata_o,
    output logic        zero_o,
    output logic        overflow_o,
    output logic [31:0] instr_o,
    output logic [31:0] pipe_npc_o,
    output logic [4:0]  wsel_o,
    output rfInMux      rfInSel_o,
    output logic        rfWEN_o,
    output logic        dREN_o,
    output logic        dWEN_o,
    output logic        halt_o
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    fwdSel_t     fwd_a;
    fwdSel_t     fwd_b;
    logic [31:0] op_a;
    logic [31:0] rt_val;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_overflow;

    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];

    assign fwd_a = fwd_select(rs, mem_wsel, mem_rfWEN, wb_wsel, wb_rfWEN);
    assign fwd_b = fwd_select(rt, mem_wsel, mem_rfWEN, wb_wsel, wb_rfWEN);

    // Operand A: newest in-flight value of rs
    always_comb begin
        case (fwd_a)
            FWD_MEM: op_a = mem_data;
            FWD_WB:  op_a = wb_data;
            default: op_a = rdat1_i;
        endcase
    end

    // rt value: feeds both the store data path and the register leg of the B mux
    always_comb begin
        case (fwd_b)
            FWD_MEM: rt_val = mem_data;
            FWD_WB:  rt_val = wb_data;
            default: rt_val = rdat2_i;
        endcase
    end

    // Operand B select; LUI places the immediate in the upper half
    always_comb begin
        case (aluBSel_i)
            BSEL_RDAT2: op_b = rt_val;
            BSEL_EXT32: op_b = ext32_i;
            BSEL_SHAMT: op_b = extshamt_i;
            default:    op_b = {instr_i[15:0], 16'h0};
        endcase
    end

    alu u_alu (
        .a        (op_a),
        .b        (op_b),
        .aluop    (aluop_i),
        .out      (alu_out),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    // EX/MEM register: flush bubbles everything but the sticky halt, EN=0 holds
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            aluout_o    <= 32'h0;
            storedata_o <= 32'h0;
            zero_o      <= 1'b0;
            overflow_o  <= 1'b0;
            instr_o     <= 32'h0;
            pipe_npc_o  <= 32'h0;
            wsel_o      <= 5'd0;
            rfInSel_o   <= rfInMux'(2'd0);
            rfWEN_o     <= 1'b0;
            dREN_o      <= 1'b0;
            dWEN_o      <= 1'b0;
            halt_o      <= 1'b0;
        end else if (flush) begin
            aluout_o    <= 32'h0;
            storedata_o <= 32'h0;
            zero_o      <= 1'b0;
            overflow_o  <= 1'b0;
            instr_o     <= 32'h0;
            pipe_npc_o  <= 32'h0;
            wsel_o      <= 5'd0;
            rfInSel_o   <= rfInMux'(2'd0);
            rfWEN_o     <= 1'b0;
            dREN_o      <= 1'b0;
            dWEN_o      <= 1'b0;
        end else if (EN) begin
            aluout_o    <= alu_out;
            storedata_o <= rt_val;
            zero_o      <= alu_zero;
            overflow_o  <= alu_overflow;
            instr_o     <= instr_i;
            pipe_npc_o  <= pipe_npc_i;
            wsel_o      <= wsel_i;
            rfInSel_o   <= rfInSel_i;
            rfWEN_o     <= rfWEN_i && (wsel_i != 5'd0);
            dREN_o      <= dREN_i;
            dWEN_o      <= dWEN_i;
            halt_o      <= halt_o | halt_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized and directed self-checking bench for ex_stage
module tb_ex_stage;
    import mux_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        EN;
    logic        flush;
    logic [31:0] instr_i;
    logic [31:0] pipe_npc_i;
    logic [31:0] rdat1_i;
    logic [31:0] rdat2_i;
    logic [31:0] ext32_i;
    logic [31:0] extshamt_i;
    aluBMux      aluBSel_i;
    aluop_t      aluop_i;
    logic [4:0]  wsel_i;
    rfInMux      rfInSel_i;
    logic        rfWEN_i;
    logic        dREN_i;
    logic        dWEN_i;
    logic        halt_i;
    logic [4:0]  mem_wsel;
    logic        mem_rfWEN;
    logic [31:0] mem_data;
    logic [4:0]  wb_wsel;
    logic        wb_rfWEN;
    logic [31:0] wb_data;
    logic [31:0] aluout_o;
    logic [31:0] storedata_o;
    logic        zero_o;
    logic        overflow_o;
    logic [31:0] instr_o;
    logic [31:0] pipe_npc_o;
    logic [4:0]  wsel_o;
    rfInMux      rfInSel_o;
    logic        rfWEN_o;
    logic        dREN_o;
    logic        dWEN_o;
    logic        halt_o;

    int checks = 0;
    int fails  = 0;
    bit cmp_on = 1'b0;

    ex_stage dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .EN          (EN),
        .flush       (flush),
        .instr_i     (instr_i),
        .pipe_npc_i  (pipe_npc_i),
        .rdat1_i     (rdat1_i),
        .rdat2_i     (rdat2_i),
        .ext32_i     (ext32_i),
        .extshamt_i  (extshamt_i),
        .aluBSel_i   (aluBSel_i),
        .aluop_i     (aluop_i),
        .wsel_i      (wsel_i),
        .rfInSel_i   (rfInSel_i),
        .rfWEN_i     (rfWEN_i),
        .dREN_i      (dREN_i),
        .dWEN_i      (dWEN_i),
        .halt_i      (halt_i),
        .mem_wsel    (mem_wsel),
        .mem_rfWEN   (mem_rfWEN),
        .mem_data    (mem_data),
        .wb_wsel     (wb_wsel),
        .wb_rfWEN    (wb_rfWEN),
        .wb_data     (wb_data),
        .aluout_o    (aluout_o),
        .storedata_o (storedata_o),
        .zero_o      (zero_o),
        .overflow_o  (overflow_o),
        .instr_o     (instr_o),
        .pipe_npc_o  (pipe_npc_o),
        .wsel_o      (wsel_o),
        .rfInSel_o   (rfInSel_o),
        .rfWEN_o     (rfWEN_o),
        .dREN_o      (dREN_o),
        .dWEN_o      (dWEN_o),
        .halt_o      (halt_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] dflt);
        if (r == 5'd0) return dflt;
        if (mem_rfWEN && mem_wsel == r) return mem_data;
        if (wb_rfWEN && wb_wsel == r) return wb_data;
        return dflt;
    endfunction

    function automatic logic [31:0] opb_ref();
        logic [31:0] rtv;
        logic [31:0] imm;
        rtv = fwd_ref(instr_i[20:16], rdat2_i);
        imm = {instr_i[15:0], 16'h0};
        case (aluBSel_i)
            BSEL_RDAT2: return rtv;
            BSEL_EXT32: return ext32_i;
            BSEL_SHAMT: return extshamt_i;
            default:    return imm;
        endcase
    endfunction

    // Returns {overflow, result}; arithmetic done in 64-bit signed and range-checked
    function automatic logic [32:0] ref_alu(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r, ua, ub;
        longint hi_lim, lo_lim;
        logic [31:0] lo;
        logic [31:0] pw;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        hi_lim = 64'sd2147483647;
        lo_lim = -64'sd2147483648;
        pw = 32'd1 << a[4:0];
        ovf = 1'b0;
        lo = 32'h0;
        r = 0;
        case (op)
            ALU_SLL:  lo = b * pw;
            ALU_SRL:  lo = b / pw;
            ALU_ADD:  begin r = sa + sb; lo = r[31:0]; ovf = (r > hi_lim) || (r < lo_lim); end
            ALU_SUB:  begin r = sa - sb; lo = r[31:0]; ovf = (r > hi_lim) || (r < lo_lim); end
            ALU_AND:  lo = a & b;
            ALU_OR:   lo = a | b;
            ALU_XOR:  lo = a ^ b;
            ALU_NOR:  lo = ~(a | b);
            ALU_SLT:  lo = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: lo = (ua < ub) ? 32'd1 : 32'd0;
            default:  lo = 32'h0;
        endcase
        return {ovf, lo};
    endfunction

    logic [31:0] m_alu, m_store, m_instr, m_npc;
    logic        m_ovf, m_rfwen, m_dren, m_dwen, m_halt;
    logic [4:0]  m_wsel;
    logic [1:0]  m_rfin;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_alu <= 0; m_store <= 0; m_instr <= 0; m_npc <= 0; m_ovf <= 0;
            m_rfwen <= 0; m_dren <= 0; m_dwen <= 0; m_halt <= 0; m_wsel <= 0; m_rfin <= 0;
        end else if (flush) begin
            m_alu <= 0; m_store <= 0; m_instr <= 0; m_npc <= 0; m_ovf <= 0;
            m_rfwen <= 0; m_dren <= 0; m_dwen <= 0; m_wsel <= 0; m_rfin <= 0;
        end else if (EN) begin
            {m_ovf, m_alu} <= ref_alu(aluop_i, fwd_ref(instr_i[25:21], rdat1_i), opb_ref());
            m_store <= fwd_ref(instr_i[20:16], rdat2_i);
            m_instr <= instr_i;
            m_npc   <= pipe_npc_i;
            m_wsel  <= wsel_i;
            m_rfin  <= rfInSel_i;
            m_rfwen <= rfWEN_i && (wsel_i != 5'd0);
            m_dren  <= dREN_i;
            m_dwen  <= dWEN_i;
            m_halt  <= m_halt | halt_i;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge CLK) begin
        if (cmp_on) begin
            check("aluout", aluout_o, m_alu);
            check("storedata", storedata_o, m_store);
            check("zero", {31'h0, zero_o}, {31'h0, (m_alu == 32'h0) && (m_instr != 32'h0 || m_alu == 32'h0) && !(m_alu != 0)} & {31'h0, !(m_rfwen === 1'bx)} & {31'h0, zero_exp()});
            check("overflow", {31'h0, overflow_o}, {31'h0, m_ovf});
            check("instr", instr_o, m_instr);
            check("npc", pipe_npc_o, m_npc);
            check("wsel", {27'h0, wsel_o}, {27'h0, m_wsel});
            check("rfinsel", {30'h0, rfInSel_o}, {30'h0, m_rfin});
            check("rfwen", {31'h0, rfWEN_o}, {31'h0, m_rfwen});
            check("dren", {31'h0, dREN_o}, {31'h0, m_dren});
            check("dwen", {31'h0, dWEN_o}, {31'h0, m_dwen});
            check("halt", {31'h0, halt_o}, {31'h0, m_halt});
        end
    end

    // zero is only set by a real capture; a bubble or reset leaves it 0
    logic m_zero;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)      m_zero <= 1'b0;
        else if (flush) m_zero <= 1'b0;
        else if (EN)    m_zero <= (ref_alu(aluop_i, fwd_ref(instr_i[25:21], rdat1_i), opb_ref()) & 33'h0_FFFF_FFFF) == 33'h0;
    end
    function automatic logic zero_exp();
        return m_zero;
    endfunction

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_inputs();
        EN = 1'b1; flush = 1'b0; instr_i = 0; pipe_npc_i = 0; rdat1_i = 0; rdat2_i = 0;
        ext32_i = 0; extshamt_i = 0; aluBSel_i = BSEL_RDAT2; aluop_i = ALU_ADD; wsel_i = 0;
        rfInSel_i = RFIN_ALU; rfWEN_i = 0; dREN_i = 0; dWEN_i = 0; halt_i = 0;
        mem_wsel = 0; mem_rfWEN = 0; mem_data = 0; wb_wsel = 0; wb_rfWEN = 0; wb_data = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h0, rs, rt, imm};
    endfunction

    initial begin
        clear_inputs();
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #1;
        cmp_on = 1'b1;
        check("reset aluout", aluout_o, 32'h0);
        check("reset halt", {31'h0, halt_o}, 32'h0);
        @(negedge CLK); #1;
        nRST = 1'b1;

        // signed overflow on ADD
        instr_i = mk_instr(5'd1, 5'd2, 16'h0); rdat1_i = 32'h7FFF_FFFF; rdat2_i = 32'h1;
        step();
        check("add ovf aluout", aluout_o, 32'h8000_0000);
        check("add ovf flag", {31'h0, overflow_o}, 32'h1);
        check("add ovf zero", {31'h0, zero_o}, 32'h0);

        // MEM beats WB, then WB when MEM not writing
        instr_i = mk_instr(5'd5, 5'd0, 16'h0); rdat1_i = 32'h30; rdat2_i = 0;
        mem_wsel = 5'd5; mem_rfWEN = 1; mem_data = 32'h10;
        wb_wsel = 5'd5; wb_rfWEN = 1; wb_data = 32'h20;
        step();
        check("fwd mem", aluout_o, 32'h10);
        mem_rfWEN = 0;
        step();
        check("fwd wb", aluout_o, 32'h20);

        // $0 never forwarded
        instr_i = mk_instr(5'd0, 5'd0, 16'h0); rdat1_i = 0; rdat2_i = 0;
        mem_wsel = 0; mem_rfWEN = 1; mem_data = 32'hFF; wb_rfWEN = 0;
        step();
        check("r0 nofwd aluout", aluout_o, 32'h0);
        check("r0 nofwd zero", {31'h0, zero_o}, 32'h1);
        mem_rfWEN = 0;

        // sticky halt across flush, cleared by reset
        halt_i = 1;
        step();
        check("halt set", {31'h0, halt_o}, 32'h1);
        halt_i = 0; rdat1_i = 32'h5; wsel_i = 5'd3; rfWEN_i = 1; flush = 1;
        step();
        check("flush aluout", aluout_o, 32'h0);
        check("flush rfwen", {31'h0, rfWEN_o}, 32'h0);
        check("flush keeps halt", {31'h0, halt_o}, 32'h1);
        flush = 0; EN = 0;
        step();
        check("halt held", {31'h0, halt_o}, 32'h1);
        #1 nRST = 0;
        #1 check("halt cleared", {31'h0, halt_o}, 32'h0);
        #1 nRST = 1;
        EN = 1;

        // stall holds, then flush with EN bubbles
        instr_i = mk_instr(5'd1, 5'd2, 16'h0); rdat1_i = 32'd3; rdat2_i = 32'd4;
        wsel_i = 5'd4; rfWEN_i = 1; dWEN_i = 1;
        step();
        check("pre-stall aluout", aluout_o, 32'd7);
        EN = 0;
        for (int i = 0; i < 3; i++) begin
            rdat1_i = $urandom; rdat2_i = $urandom; wsel_i = 5'(i + 7);
            step();
            check("stall aluout", aluout_o, 32'd7);
            check("stall wsel", {27'h0, wsel_o}, 32'd4);
        end
        EN = 1; flush = 1;
        step();
        check("flush en rfwen", {31'h0, rfWEN_o}, 32'h0);
        check("flush en dwen", {31'h0, dWEN_o}, 32'h0);
        check("flush en aluout", aluout_o, 32'h0);
        flush = 0; dWEN_i = 0;

        // SLT / SLTU / LUI
        rdat1_i = 32'hFFFF_FFFF; rdat2_i = 32'h1; aluop_i = ALU_SLT;
        step();
        check("slt", aluout_o, 32'h1);
        aluop_i = ALU_SLTU;
        step();
        check("sltu", aluout_o, 32'h0);
        instr_i = mk_instr(5'd0, 5'd0, 16'hABCD); rdat1_i = 0; aluBSel_i = BSEL_LUI; aluop_i = ALU_OR;
        step();
        check("lui", aluout_o, 32'hABCD_0000);

        // write to $0 is suppressed
        wsel_i = 5'd0; rfWEN_i = 1;
        step();
        check("r0 rfwen", {31'h0, rfWEN_o}, 32'h0);

        // model self-pins
        check("model sll", ref_alu(ALU_SLL, 32'd4, 32'h1)   & 33'h0_FFFF_FFFF, 33'h10);
        check("model sub ovf", {31'h0, ref_alu(ALU_SUB, 32'h8000_0000, 32'h1) > 33'h0_FFFF_FFFF}, 32'h1);

        // randomized phase
        for (int n = 0; n < 800; n++) begin
            @(negedge CLK); #1;
            EN = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 11) == 0);
            halt_i = ($urandom_range(0, 59) == 0);
            instr_i = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            pipe_npc_i = $urandom;
            rdat1_i = rand_word(); rdat2_i = rand_word();
            ext32_i = rand_word(); extshamt_i = 32'($urandom_range(0, 31));
            aluBSel_i = aluBMux'(2'($urandom_range(0, 3)));
            aluop_i = aluop_t'(4'($urandom_range(0, 15)));
            wsel_i = 5'($urandom_range(0, 31));
            rfInSel_i = rfInMux'(2'($urandom_range(0, 3)));
            rfWEN_i = 1'($urandom); dREN_i = 1'($urandom); dWEN_i = 1'($urandom);
            mem_wsel = 5'($urandom_range(0, 3)); mem_rfWEN = 1'($urandom); mem_data = rand_word();
            wb_wsel = 5'($urandom_range(0, 3)); wb_rfWEN = 1'($urandom); wb_data = rand_word();
            if ($urandom_range(0, 79) == 0) begin
                #1 nRST = 0;
                #1 nRST = 1;
            end
        end

        @(negedge CLK); #1;
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: CLK in 1, single clock, all state on rising edge; nRST in 1, asynchronous active-low reset.
REQ-002 SHALL take ID/EX fields: EN in 1 stage advance; flush in 1 bubble insert; instr_i in 32; pipe_npc_i in 32; rdat1_i in 32; rdat2_i in 32; ext32_i in 32; extshamt_i in 32.
REQ-003 SHALL take ID/EX controls: aluBSel_i in aluBMux; aluop_i in aluop_t; wsel_i in 5; rfInSel_i in rfInMux; rfWEN_i in 1; dREN_i in 1; dWEN_i in 1; halt_i in 1.
REQ-004 SHALL take forwarding sources: mem_wsel in 5; mem_rfWEN in 1; mem_data in 32; wb_wsel in 5; wb_rfWEN in 1; wb_data in 32.
REQ-005 SHALL drive registered EX/MEM outputs: aluout_o out 32; storedata_o out 32; zero_o out 1; overflow_o out 1; instr_o out 32; pipe_npc_o out 32; wsel_o out 5; rfInSel_o out rfInMux; rfWEN_o out 1; dREN_o out 1; dWEN_o out 1; halt_o out 1.

Function
REQ-006 SHALL take rs = instr_i[25:21], rt = instr_i[20:16].
REQ-007 SHALL forward operand A: mem_data when mem_rfWEN && mem_wsel==rs && rs!=0; else wb_data when wb_rfWEN && wb_wsel==rs && rs!=0; else rdat1_i.
REQ-008 SHALL forward rt value by the same rule (MEM beats WB, $0 never forwarded); the result is storedata and the RDAT2 leg of the B mux.
REQ-009 SHALL select operand B by aluBSel_i: RDAT2 -> forwarded rt; EXT32 -> ext32_i; SHAMT -> extshamt_i; LUI -> {instr_i[15:0],16'h0}.
REQ-010 SHALL compute by aluop_i: SLL B<<A[4:0]; SRL B>>A[4:0]; ADD A+B; SUB A-B; AND; OR; XOR; NOR; SLT signed (0/1); SLTU unsigned (0/1); undefined encodings -> 0.
REQ-011 SHALL set overflow for ADD/SUB only: signed two's-complement overflow; 0 for all other ops; result still wraps modulo 2^32.
REQ-012 SHALL set zero = (32-bit result == 0).
REQ-013 SHALL latch all outputs one cycle after inputs: latency 1, on a rising edge with EN=1, flush=0.
REQ-014 SHALL hold all outputs when EN=0 and flush=0 (stall).
REQ-015 SHALL zero all outputs except halt_o on flush=1, regardless of EN (flush beats EN).
REQ-016 SHALL make halt_o sticky: set on a capture edge with halt_i=1; cleared only by nRST; unaffected by flush.
REQ-017 SHALL suppress rfWEN_o when wsel_i==0 (captured as 0).
REQ-018 SHALL make forwarding purely combinational from the current forwarding inputs; no operand is registered before the ALU.

Reset
REQ-019 SHALL set every output to 0 on nRST low, including halt_o; enum outputs are cast 0.
REQ-020 SHALL apply reset immediately (asynchronous) even mid-stall or mid-flush; the first capture is the first rising edge after release with EN=1.

Structure
REQ-021 SHALL take aluop_t, aluBMux and rfInMux from mux_types_pkg; new fwdSel_t (NONE, MEM, WB) SHALL be added there.
REQ-022 SHALL contain the combinational ALU as sub-module alu (ports: a, b, aluop, out, zero, overflow); forwarding, muxing and the output register stay in ex_stage.

Verification
REQ-023 SHALL test ADD of 0x7FFFFFFF + 0x00000001, RDAT2, EN=1 -> next edge aluout_o=0x80000000, overflow_o=1, zero_o=0.
REQ-024 SHALL test rs=5, mem_wsel=5 mem_rfWEN=1 mem_data=0x10, wb_wsel=5 wb_rfWEN=1 wb_data=0x20, rdat1=0x30, rt=0 rdat2=0, ADD -> aluout_o=0x10; with mem_rfWEN=0 -> 0x20.
REQ-025 SHALL test rs=0, mem_wsel=0 mem_rfWEN=1 mem_data=0xFF, rdat1_i=0 -> no forwarding, ADD with B=0 gives aluout_o=0, zero_o=1.
REQ-026 SHALL test halt_i=1 captured, then flush=1 -> other outputs 0, halt_o stays 1 until nRST pulse, then halt_o=0.
REQ-027 SHALL test EN=0 for 3 cycles while inputs change -> outputs constant; flush=1 with EN=1 -> rfWEN_o=0, dWEN_o=0, aluout_o=0.
REQ-028 SHALL test SLT A=0xFFFFFFFF B=1 -> aluout_o=1; SLTU on the same operands -> 0; LUI with instr_i[15:0]=0xABCD, OR A=0 -> 0xABCD0000.
